// File: rtl/cntr_param.sv
// cntr_param: parametrised up/down event/timer counter.
// Configurable width and modulus, clock-enable prescaler, direction control,
// parallel load (clamped to the modulus), wrap or saturate at the boundary,
// a one-cycle terminal-count pulse and a sticky overflow flag.
//
// There is no handshake on this block: clr, load and en are level controls
// sampled on every rising clk edge with priority clr > load > en. Outputs are
// registered and valid every cycle.
module cntr_param #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MOD_VAL = 64'd1 << WIDTH,
  parameter int              PRESC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Largest legal count value; the counter never holds anything above it.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VAL - 64'd1);

  // The prescaler needs at least one bit even when PRESC=1 (it then stays 0).
  localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0]    presc_cnt;
  logic [PW-1:0]    presc_next;
  logic             presc_wrap;
  logic             step;
  logic             at_bound;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;

  // Next-state decode: when a step happens, whether it hits the boundary,
  // and what the count becomes in each case.
  always_comb begin
    presc_wrap   = (presc_cnt == PRESC_LAST);
    presc_next   = presc_wrap ? '0 : presc_cnt + PW'(1);
    step         = en && !clr && !load && presc_wrap;
    at_bound     = up_dn ? (count == MAX_VAL) : (count == '0);
    boundary     = step && at_bound;
    load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    step_val     = count;
    if (up_dn) begin
      if (!at_bound)     step_val = count + WIDTH'(1);
      else if (!sat_mode) step_val = '0;
    end else begin
      if (!at_bound)     step_val = count - WIDTH'(1);
      else if (!sat_mode) step_val = MAX_VAL;
    end
  end

  // Registered state: count, prescaler, tc pulse and sticky ovf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      presc_cnt <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      // boundary is already gated off by clr/load, so tc drops on those cycles.
      tc <= boundary;
      // A boundary event in the same cycle as ovf_clr keeps the flag set.
      if (boundary)     ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (clr) begin
        count     <= '0;
        presc_cnt <= '0;
      end else if (load) begin
        count     <= load_clamped;
        presc_cnt <= '0;
      end else if (en) begin
        presc_cnt <= presc_next;
        if (step) count <= step_val;
      end
    end
  end

endmodule
